// File: rtl/lifo_reader.sv
// Burst pop engine for the read side of a LIFO: pops a requested number of words and streams them
// newest-first over valid/ready. Optional stall counter enabled by defining LIFO_READER_STATS_EN.
module lifo_reader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   burst_len_i,
    output logic              busy_o,
    output logic              rdreq_o,
    input  logic [DWIDTH-1:0] q_i,
    input  logic [AWIDTH:0]   usedw_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic              done_o,
    output logic [AWIDTH:0]   count_o
`ifdef LIFO_READER_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    // Stream handshake: a word moves when valid_o && ready_i at a rising edge; while valid_o is
    // high and ready_i low, data_o/last_o/valid_o do not change.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AWIDTH:0] ONE = {{AWIDTH{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH:0]   target;
    logic [AWIDTH:0]   issued;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   start_target;
    logic              inflight;
    logic [DWIDTH-1:0] skid [0:2];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        occ;
    logic              push;
    logic              pop;
    logic              accept;

    // A zero or oversized request collapses to whatever the LIFO currently holds.
    always_comb begin
        start_target = burst_len_i;
        if (burst_len_i == '0 || burst_len_i > usedw_i) begin
            start_target = usedw_i;
        end
    end

    assign accept  = (state == S_IDLE) && start_i;
    assign push    = inflight;
    assign valid_o = (occ != 2'd0);
    assign pop     = valid_o && ready_i;
    assign data_o  = skid[rd_ptr];
    assign last_o  = valid_o && ((count + ONE) == target);
    assign busy_o  = (state != S_IDLE);
    assign done_o  = (state == S_DONE);
    assign count_o = count;

    // Issue only while the skid buffer is guaranteed room for everything already requested.
    always_comb begin
        rdreq_o = 1'b0;
        if (state == S_RUN && issued < target &&
            ({1'b0, occ} + {2'b00, inflight}) < 3'd3) begin
            rdreq_o = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (start_target == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issued == target) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!inflight && occ == 2'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            target   <= '0;
            issued   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rdreq_o;
            if (accept) begin
                target <= start_target;
                issued <= '0;
                count  <= '0;
            end else begin
                if (rdreq_o) begin
                    issued <= issued + ONE;
                end
                if (pop) begin
                    count <= count + ONE;
                end
            end
        end
    end

    // Three-entry FIFO that absorbs the LIFO's read latency and downstream backpressure.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            for (int i = 0; i < 3; i++) begin
                skid[i] <= '0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                skid[wr_ptr] <= q_i;
                wr_ptr       <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef LIFO_READER_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            stall_cnt <= '0;
        end else if (valid_o && !ready_i && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: a behavioural LIFO feeds the DUT, an expected queue of newest-first words
// checks the stream, and random backpressure exercises stalls.
module tb_lifo_reader;

    localparam int DWIDTH = 16;
    localparam int AWIDTH = 8;
    localparam int DEPTH  = 1 << AWIDTH;

    logic              clk_i_tb;
    logic              srst_i;
    logic              start_i;
    logic [AWIDTH:0]   burst_len_i;
    logic              busy_o;
    logic              rdreq_o;
    logic [DWIDTH-1:0] q_i;
    logic [AWIDTH:0]   usedw_i;
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i;
    logic              done_o;
    logic [AWIDTH:0]   count_o;
`ifdef LIFO_READER_STATS_EN
    logic [15:0]       stall_cnt_o;
`endif

    lifo_reader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk_i       (clk_i_tb),
        .srst_i      (srst_i),
        .start_i     (start_i),
        .burst_len_i (burst_len_i),
        .busy_o      (busy_o),
        .rdreq_o     (rdreq_o),
        .q_i         (q_i),
        .usedw_i     (usedw_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i),
        .done_o      (done_o),
        .count_o     (count_o)
`ifdef LIFO_READER_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // Clock / reset
    initial clk_i_tb = 1'b0;
    always #5 clk_i_tb = ~clk_i_tb;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural LIFO: pop on rdreq, data appears on q_i one cycle later.
    logic [DWIDTH-1:0] mem [DEPTH];
    int sp = 0;
    int popped = 0;
    int transferred = 0;

    assign usedw_i = sp[AWIDTH:0];

    always @(posedge clk_i_tb) begin
        if (rdreq_o) begin
            check("underflow", (sp > 0), 1);
            if (sp > 0) begin
                q_i <= mem[sp-1];
                sp = sp - 1;
                popped++;
            end
        end
    end

    task automatic lifo_clear();
        sp = 0;
    endtask

    task automatic lifo_preload(input int n);
        for (int i = 0; i < n; i++) begin
            mem[sp] = DWIDTH'($urandom);
            sp++;
        end
    endtask

    // Random backpressure
    int ready_pct = 100;
    always @(posedge clk_i_tb) begin
        #1;
        ready_i = ($urandom_range(0, 99) < ready_pct);
    end

    // Scoreboard
    logic [DWIDTH-1:0] exp_q[$];
    int                exp_target = 0;
    logic              prev_stall = 1'b0;
    logic [DWIDTH-1:0] prev_data;
    logic              prev_last;
    int                stall_exp = 0;

    always @(negedge clk_i_tb) begin
        if (srst_i) begin
            prev_stall = 1'b0;
            stall_exp  = 0;
        end else begin
            // Everything popped but not yet delivered sits in flight or in the skid buffer.
            if (rdreq_o) check("rdreq_window", ((popped - transferred) < 3), 1);
            if (done_o) check("done_vs_valid", valid_o, 0);
            if (prev_stall) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", data_o, prev_data);
                check("hold_last", last_o, prev_last);
            end
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", valid_o, 0);
                end else begin
                    check("last", last_o, (exp_q.size() == 1));
                    if (ready_i) begin
                        check("count_before", count_o, exp_target - exp_q.size());
                        check("data", data_o, exp_q.pop_front());
                        transferred++;
                    end
                end
            end
            if (valid_o && !ready_i && stall_exp != 16'hFFFF) stall_exp++;
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
        end
    end

    // Driver: one burst from start pulse to done, optionally poking start while busy or resetting mid-burst.
    task automatic run_burst(input int len, input int rpct, input bit poke, input int reset_after);
        int tgt, remain, k, first_v, last_x, nx;
        bit seen_done, aborted;
        @(posedge clk_i_tb);
        #1;
        ready_pct = rpct;
        tgt = (len == 0 || len > sp) ? sp : len;
        for (int i = 0; i < tgt; i++) exp_q.push_back(mem[sp-1-i]);
        exp_target = tgt;
        remain = sp - tgt;
        start_i = 1'b1;
        burst_len_i = len[AWIDTH:0];
        @(posedge clk_i_tb);
        #1;
        start_i = 1'b0;
        k = 0; first_v = 0; last_x = 0; nx = 0;
        seen_done = 0; aborted = 0;
        while (!seen_done && !aborted && k < 5000) begin
            @(negedge clk_i_tb);
            k++;
            if (valid_o && first_v == 0) first_v = k;
            if (valid_o && ready_i) begin
                last_x = k;
                nx++;
            end
            if (done_o) seen_done = 1;
            if (poke && k == 4) begin
                start_i = 1'b1;
                burst_len_i = AWIDTH'($urandom_range(1, 9));
            end else begin
                start_i = 1'b0;
            end
            if (reset_after >= 0 && nx == reset_after) begin
                @(posedge clk_i_tb);
                #2;
                srst_i = 1'b1;
                #1;
                check("rst_valid", valid_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_rdreq", rdreq_o, 0);
                check("rst_count", count_o, 0);
                check("rst_data", data_o, 0);
                check("rst_last", last_o, 0);
                exp_q.delete();
                popped = 0;
                transferred = 0;
                repeat (2) @(negedge clk_i_tb);
                srst_i = 1'b0;
                aborted = 1;
            end
        end
        if (!aborted) begin
            check("done_seen", seen_done, 1);
            check("count_final", count_o, tgt);
            if (tgt == 0) begin
                check("empty_done_lat", k, 1);
                check("empty_no_valid", first_v, 0);
            end else begin
                check("first_valid_lat", first_v, 3);
                if (rpct == 100) check("throughput", last_x - first_v, tgt - 1);
            end
            @(negedge clk_i_tb);
            check("busy_after_done", busy_o, 0);
            check("done_one_cycle", done_o, 0);
            check("exp_drained", exp_q.size(), 0);
            check("usedw_after", sp, remain);
            popped = 0;
            transferred = 0;
        end
    endtask

    initial begin
        srst_i = 1'b1;
        start_i = 1'b0;
        burst_len_i = '0;
        ready_i = 1'b1;
        q_i = '0;
        repeat (3) @(negedge clk_i_tb);
        check("reset_busy", busy_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_rdreq", rdreq_o, 0);
        check("reset_done", done_o, 0);
        check("reset_count", count_o, 0);
        check("reset_data", data_o, 0);
        check("reset_last", last_o, 0);
`ifdef LIFO_READER_STATS_EN
        check("reset_stall", stall_cnt_o, 0);
`endif
        srst_i = 1'b0;

        lifo_clear(); lifo_preload(10);
        run_burst(4, 100, 0, -1);

        lifo_clear(); lifo_preload(5);
        run_burst(0, 100, 0, -1);

        run_burst(7, 100, 0, -1);

        lifo_clear(); lifo_preload(256);
        run_burst(256, 50, 1, -1);

        lifo_clear(); lifo_preload(20);
        run_burst(20, 100, 0, 6);
        run_burst(0, 100, 0, -1);

        for (int it = 0; it < 8; it++) begin
            lifo_preload($urandom_range(0, (DEPTH - sp) < 60 ? (DEPTH - sp) : 60));
            run_burst($urandom_range(0, 40), $urandom_range(30, 100), it[0], -1);
        end

`ifdef LIFO_READER_STATS_EN
        @(negedge clk_i_tb);
        check("stall_cnt", stall_cnt_o, stall_exp);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
